// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding mux
// selects, MDU FSM state codes and the register-match helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_mdu_fsm.sv
// Tracks how long a multi-cycle multiply/divide keeps the EX stage occupied.
// The op's last EX cycle happens back in IDLE, so BUSY spans MDU_LAT-1 cycles.
module hazard_mdu_fsm
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic mdu_start,
  output logic mdu_busy
);

  logic       state;
  logic [3:0] cnt;

  // State and down-counter; a start seen while already busy is ignored.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else if (state == ST_IDLE) begin
      if (mdu_start) begin
        state <= ST_BUSY;
        cnt   <= 4'(MDU_LAT - 2);
      end
    end else begin
      if (cnt == 4'd0) begin
        state <= ST_IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign mdu_busy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage MIPS core: decode/EX forwarding,
// load-use and branch stalls, flushes, and MDU occupancy of EX.
// Optional feature: define HAZ_STALL_CNT_EN to get a saturating count of
// decode stall cycles on StallCnt; otherwise StallCnt is tied to zero.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             BranchD,
  input  logic             PCsrcD,
  input  logic             MduStartE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCnt
);

  logic lw_stall;
  logic br_stall;
  logic hz_stall;

  hazard_mdu_fsm #(.MDU_LAT(MDU_LAT)) u_mdu_fsm (
    .CLK       (CLK),
    .reset     (reset),
    .mdu_start (MduStartE),
    .mdu_busy  (MduBusy)
  );

  // EX operand forwarding: the younger result in MEM wins over WB.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && reg_match(WriteRegM, rsE))      ForwardAE = FWD_MEM;
    else if (RegWriteW && reg_match(WriteRegW, rsE)) ForwardAE = FWD_WB;
    if (RegWriteM && reg_match(WriteRegM, rtE))      ForwardBE = FWD_MEM;
    else if (RegWriteW && reg_match(WriteRegW, rtE)) ForwardBE = FWD_WB;
  end

  // Branch compare in decode can only take an ALU result from MEM, not load data.
  assign ForwardAD = RegWriteM && reg_match(WriteRegM, rsD) && !MemToRegM;
  assign ForwardBD = RegWriteM && reg_match(WriteRegM, rtD) && !MemToRegM;

  assign lw_stall = MemToRegE && (reg_match(rtE, rsD) || reg_match(rtE, rtD));
  assign br_stall = BranchD &&
                    ((RegWriteE && (reg_match(WriteRegE, rsD) || reg_match(WriteRegE, rtD))) ||
                     (MemToRegM && (reg_match(WriteRegM, rsD) || reg_match(WriteRegM, rtD))));
  assign hz_stall = lw_stall || br_stall;

  // An MDU op in EX freezes the front of the pipe and bubbles MEM,
  // overriding any decode-stage hazard or taken branch.
  always_comb begin
    StallF = hz_stall;
    StallD = hz_stall;
    StallE = 1'b0;
    FlushE = hz_stall;
    FlushM = 1'b0;
    FlushD = PCsrcD && !hz_stall;
    if (MduBusy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushE = 1'b0;
      FlushM = 1'b1;
      FlushD = 1'b0;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of cycles in which decode was held.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (StallD && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign StallCnt = stall_cnt;
`else
  assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: constant vector table, hand
// sequences for the MDU and async-reset cases, and randomized cycles
// compared against a rule-level reference model.
module tb_hazard_scheduler;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 32;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, mtrE, mtrM, brD, pcsD, mduS;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [12:0] e;
    string       name;
  } vec_t;

  logic             CLK;
  logic             reset;
  stim_t            s_in;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic             ForwardAD, ForwardBD, MduBusy;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCnt;
  logic [12:0]      act;

  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               busy_until = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  vec_t             vecs[$];

  hazard_scheduler #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .rsD       (s_in.rsD),
    .rtD       (s_in.rtD),
    .rsE       (s_in.rsE),
    .rtE       (s_in.rtE),
    .WriteRegE (s_in.wrE),
    .WriteRegM (s_in.wrM),
    .WriteRegW (s_in.wrW),
    .RegWriteE (s_in.rwE),
    .RegWriteM (s_in.rwM),
    .RegWriteW (s_in.rwW),
    .MemToRegE (s_in.mtrE),
    .MemToRegM (s_in.mtrM),
    .BranchD   (s_in.brD),
    .PCsrcD    (s_in.pcsD),
    .MduStartE (s_in.mduS),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushM    (FlushM),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .MduBusy   (MduBusy),
    .StallCnt  (StallCnt)
  );

  assign act = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                ForwardAD, ForwardBD, ForwardAE, ForwardBE, MduBusy};

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hazard rules evaluated directly from the register names.
  // Bit order: StallF StallD StallE FlushD FlushE FlushM AD BD AE[2] BE[2] Busy.
  function automatic logic [12:0] model(input stim_t s, input logic busy);
    logic       lw, br, st, ad, bd;
    logic [1:0] ae, be;
    lw = s.mtrE && (s.rtE != 0) && (s.rtE == s.rsD || s.rtE == s.rtD);
    br = s.brD && ((s.rwE && (s.wrE != 0) && (s.wrE == s.rsD || s.wrE == s.rtD)) ||
                   (s.mtrM && (s.wrM != 0) && (s.wrM == s.rsD || s.wrM == s.rtD)));
    ae = (s.rwM && s.wrM != 0 && s.wrM == s.rsE) ? 2'b10 :
         (s.rwW && s.wrW != 0 && s.wrW == s.rsE) ? 2'b01 : 2'b00;
    be = (s.rwM && s.wrM != 0 && s.wrM == s.rtE) ? 2'b10 :
         (s.rwW && s.wrW != 0 && s.wrW == s.rtE) ? 2'b01 : 2'b00;
    ad = s.rwM && s.wrM != 0 && s.wrM == s.rsD && !s.mtrM;
    bd = s.rwM && s.wrM != 0 && s.wrM == s.rtD && !s.mtrM;
    st = lw || br;
    if (busy) return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ad, bd, ae, be, 1'b1};
    return {st, st, 1'b0, s.pcsD && !st, st, 1'b0, ad, bd, ae, be, 1'b0};
  endfunction

  // Reference timeline: an accepted MDU start at cycle c keeps EX busy for
  // cycles c+1 .. c+MDU_LAT-1; decode-stall cycles are tallied alongside.
  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      busy_until <= cyc;
      exp_cnt    <= '0;
    end else begin
      if (model(s_in, cyc < busy_until) & 13'b0_1000_0000_0000 ? 1'b1 : 1'b0) begin
        if (exp_cnt != '1) exp_cnt <= exp_cnt + 1'b1;
      end
      if (!(cyc < busy_until) && s_in.mduS) busy_until <= cyc + MDU_LAT;
    end
    cyc <= cyc + 1;
  end

  task automatic apply_stimulus(input stim_t s);
    s_in = s;
  endtask

  task automatic check_output(input string name, input logic [12:0] e);
    logic [CNT_W-1:0] ec;
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL %s: got %b required %b (StF StD StE FlD FlE FlM AD BD AE BE Busy)",
               name, act, e);
    end
`ifdef HAZ_STALL_CNT_EN
    ec = exp_cnt;
`else
    ec = '0;
`endif
    checks++;
    if (StallCnt !== ec) begin
      failures++;
      $display("[TB] FAIL %s_stallcnt: got %0d required %0d", name, StallCnt, ec);
    end
  endtask

  task automatic add_vec(input stim_t s, input logic [12:0] e, input string n);
    vec_t v;
    v.s = s; v.e = e; v.name = n;
    vecs.push_back(v);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Main sequence.
  initial begin
    stim_t s;
    int    busy_cycles;

    reset = 1'b0;
    s_in  = '0;
    repeat (2) @(negedge CLK);
    check_output("reset_state", 13'b0);
    #1 reset = 1'b1;

    s = '0;                                               add_vec(s, 13'b0_0_0_0_0_0_0_0_00_00_0, "all_zero");
    s = '0; s.mtrE = 1; s.rtE = 2; s.rsD = 2;             add_vec(s, 13'b1_1_0_0_1_0_0_0_00_00_0, "lw_use_rs");
    s = '0; s.mtrE = 1; s.rtE = 12; s.rtD = 12; s.rsD = 1; add_vec(s, 13'b1_1_0_0_1_0_0_0_00_00_0, "lw_use_rt");
    s = '0; s.rwM = 1; s.wrM = 3; s.rsE = 3; s.rwW = 1; s.wrW = 3;
                                                          add_vec(s, 13'b0_0_0_0_0_0_0_0_10_00_0, "fwd_mem_prio");
    s = '0; s.rwM = 1; s.wrM = 8; s.rsE = 9; s.rwW = 1; s.wrW = 9;
                                                          add_vec(s, 13'b0_0_0_0_0_0_0_0_01_00_0, "fwd_wb_a");
    s = '0; s.rwW = 1; s.wrW = 5; s.rtE = 5;              add_vec(s, 13'b0_0_0_0_0_0_0_0_00_01_0, "fwd_wb_b");
    s = '0; s.brD = 1; s.rsD = 4; s.rwE = 1; s.wrE = 4;   add_vec(s, 13'b1_1_0_0_1_0_0_0_00_00_0, "beq_dep_e");
    s = '0; s.brD = 1; s.rsD = 4; s.rwM = 1; s.wrM = 4;   add_vec(s, 13'b0_0_0_0_0_0_1_0_00_00_0, "beq_fwd_m");
    s = '0; s.brD = 1; s.mtrM = 1; s.rwM = 1; s.wrM = 6; s.rtD = 6;
                                                          add_vec(s, 13'b1_1_0_0_1_0_0_0_00_00_0, "beq_load_m");
    s = '0; s.pcsD = 1; s.rwM = 1; s.wrM = 0; s.rsE = 0;  add_vec(s, 13'b0_0_0_1_0_0_0_0_00_00_0, "flushd_reg0");
    s = '0; s.mtrE = 1; s.rtE = 0; s.rsD = 0;             add_vec(s, 13'b0_0_0_0_0_0_0_0_00_00_0, "lw_reg0");
    s = '0; s.pcsD = 1; s.mtrE = 1; s.rtE = 7; s.rtD = 7; add_vec(s, 13'b1_1_0_0_1_0_0_0_00_00_0, "pcsrc_stalled");

    foreach (vecs[i]) begin
      @(posedge CLK); #1 apply_stimulus(vecs[i].s);
      @(negedge CLK); check_output(vecs[i].name, vecs[i].e);
    end

    // Load-use stall lasts one cycle once the load has moved on.
    @(posedge CLK); #1 s = '0; s.mtrE = 1; s.rtE = 2; s.rsD = 2; apply_stimulus(s);
    @(negedge CLK); check_output("lw_once", 13'b1_1_0_0_1_0_0_0_00_00_0);
    @(posedge CLK); #1 s = '0; s.rsD = 2; s.rwM = 1; s.wrM = 2; s.mtrM = 1; apply_stimulus(s);
    @(negedge CLK); check_output("lw_after", 13'b0_0_0_0_0_0_0_0_00_00_0);

    // MDU occupancy with a load-use hazard present during BUSY.
    @(posedge CLK); #1 s = '0; s.mduS = 1; apply_stimulus(s);
    @(negedge CLK); check_output("mdu_start", 13'b0);
    busy_cycles = 0;
    @(posedge CLK); #1 s = '0; s.mtrE = 1; s.rtE = 2; s.rsD = 2; s.mduS = 1; apply_stimulus(s);
    for (int k = 0; k < MDU_LAT + 1; k++) begin
      @(negedge CLK);
      check_output("mdu_seq", model(s_in, cyc < busy_until));
      if (MduBusy === 1'b1) busy_cycles++;
      @(posedge CLK); #1 s_in.mduS = 1'b0;
    end
    checks++;
    if (busy_cycles != MDU_LAT - 1) begin
      failures++;
      $display("[TB] FAIL mdu_busy_len: got %0d required %0d", busy_cycles, MDU_LAT - 1);
    end

    // Async reset in the second BUSY cycle.
    apply_stimulus('0);
    @(posedge CLK); #1 s = '0; s.mduS = 1; apply_stimulus(s);
    @(posedge CLK); #1 apply_stimulus('0);
    @(negedge CLK); check_output("busy_first", 13'b1_1_1_0_0_1_0_0_00_00_1);
    @(posedge CLK); #2 reset = 1'b0;
    #1 check_output("reset_mid_busy", 13'b0);
    @(negedge CLK); #1 reset = 1'b1;
    @(negedge CLK); check_output("after_reset", 13'b0);
    @(negedge CLK); check_output("after_reset2", 13'b0);

    // Randomized cycles against the reference model.
    for (int n = 0; n < 400; n++) begin
      @(posedge CLK); #1;
      s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
      s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
      s.wrE = 5'($urandom_range(0, 3)); s.wrM = 5'($urandom_range(0, 3));
      s.wrW = 5'($urandom_range(0, 3));
      s.rwE = 1'($urandom); s.rwM = 1'($urandom); s.rwW = 1'($urandom);
      s.mtrE = 1'($urandom); s.mtrM = 1'($urandom); s.brD = 1'($urandom);
      s.pcsD = 1'($urandom); s.mduS = ($urandom_range(0, 7) == 0);
      apply_stimulus(s);
      @(negedge CLK); check_output("random", model(s_in, cyc < busy_until));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
